// File: rtl/mem_pkg.sv
// Shared types and helpers for the LSU data memory: funct3 size codes, FSM states,
// and the size/alignment legality checks.
package mem_pkg;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } mem_size_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

   function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] off);
      case (size)
         SZ_H, SZ_HU: return ~off[0];
         SZ_W:        return (off == 2'b00);
         default:     return 1'b1;
      endcase
   endfunction

   // Unsigned sizes only make sense for loads.
   function automatic logic size_legal(input logic [2:0] size, input logic we);
      case (size)
         SZ_B, SZ_H, SZ_W: return 1'b1;
         SZ_BU, SZ_HU:     return ~we;
         default:          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module load_align_ext
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  size,
   input  logic [1:0]  off,
   output logic [31:0] result
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    result = {{24{b[7]}}, b};
         SZ_BU:   result = {24'd0, b};
         SZ_H:    result = {{16{h[15]}}, h};
         SZ_HU:   result = {16'd0, h};
         SZ_W:    result = word;
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu_data_mem_pipelined.sv
// Byte-lane data memory with a valid/ready request port, one outstanding request and a
// held response after READ_LATENCY (1..4) cycles.
module lsu_data_mem_pipelined
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 17,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
   localparam int         LANES     = DATA_WIDTH / 8;
   localparam logic [1:0] WAIT_LAST = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   mem_state_t            state;
   logic [1:0]            cnt;
   logic                  accept;
   logic                  req_err;
   logic [1:0]            off;
   logic [ADDR_WIDTH-3:0] idx;
   logic [LANES-1:0]      be;
   logic [DATA_WIDTH-1:0] wlanes;

   logic                  we_q;
   logic                  err_q;
   logic [2:0]            size_q;
   logic [1:0]            off_q;
   logic [DATA_WIDTH-1:0] rword_q;
   logic [DATA_WIDTH-1:0] ld_data;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid & req_ready;
   assign off       = req_addr[1:0];
   assign idx       = req_addr[ADDR_WIDTH-1:2];
   assign req_err   = ~size_legal(req_size, req_we) | ~is_aligned(req_size, off);

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be     = '1;
      wlanes = req_wdata;
      case (req_size[1:0])
         2'b00: begin
            be     = LANES'(1) << off;
            wlanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be     = off[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && accept && req_we && !req_err) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 3'd0;
         off_q   <= 2'd0;
         rword_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  err_q   <= req_err;
                  size_q  <= req_size;
                  off_q   <= off;
                  rword_q <= mem[idx];
                  cnt     <= 2'd0;
                  state   <= (READ_LATENCY > 1) ? WAIT : RESP;
               end
            end
            WAIT: begin
               if (cnt == WAIT_LAST) state <= RESP;
               else                  cnt   <= cnt + 2'd1;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   load_align_ext u_align (
      .word   (rword_q),
      .size   (size_q),
      .off    (off_q),
      .result (ld_data)
   );

   assign rsp_rdata = (err_q | we_q) ? '0 : ld_data;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_data_mem_pipelined.sv
// Directed bench: a latency-1 and a latency-3 instance share stimulus; each step checks
// hand-computed data, error and latency with immediate assertions.
module tb_lsu_data_mem_pipelined;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       rv;
   logic             req_we;
   logic [2:0]       req_size;
   logic [16:0]      req_addr;
   logic [31:0]      req_wdata;
   logic             rsp_ready;
   logic [1:0]       rdy, rvld, rerr;
   logic [1:0][31:0] rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lsu_data_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rvld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[0]), .rsp_err(rerr[0])
   );

   lsu_data_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .READ_LATENCY(3)) u_lat3 (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rvld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[1]), .rsp_err(rerr[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request into both instances; response captured at the cycle rsp_valid rises.
   task automatic txn(input string tag, input logic we, input logic [2:0] sz,
                      input logic [16:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      int          lat    [2];
      logic [31:0] got_rd [2];
      logic        got_err[2];
      for (int i = 0; i < 2; i++) begin
         lat[i] = 0; got_rd[i] = 'x; got_err[i] = 1'bx;
      end
      @(negedge clk);
      req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      rv = 2'b11; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rv = 2'b00;
      for (int c = 1; c <= 20; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (lat[i] == 0 && rvld[i]) begin
               lat[i] = c; got_rd[i] = rdata[i]; got_err[i] = rerr[i];
            end
         end
         if (lat[0] != 0 && lat[1] != 0) break;
         @(negedge clk);
      end
      chk({tag, "_rdata_l1"}, got_rd[0], exp_rd);
      chk({tag, "_rdata_l3"}, got_rd[1], exp_rd);
      chk({tag, "_err_l1"}, 32'(got_err[0]), 32'(exp_err));
      chk({tag, "_err_l3"}, 32'(got_err[1]), 32'(exp_err));
      chk({tag, "_lat_l1"}, 32'(lat[0]), 32'd1);
      chk({tag, "_lat_l3"}, 32'(lat[1]), 32'd3);
   endtask

   task automatic hold_test();
      @(negedge clk);
      req_we = 1'b0; req_size = 3'b010; req_addr = 17'h100; req_wdata = '0;
      rv = 2'b11; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rv = 2'b00;
      for (int c = 1; c <= 8; c++) begin
         chk("hold_ready_l1", 32'(rdy[0]), 32'd0);
         chk("hold_ready_l3", 32'(rdy[1]), 32'd0);
         chk("hold_valid_l1", 32'(rvld[0]), 32'd1);
         chk("hold_valid_l3", 32'(rvld[1]), 32'(c >= 3));
         chk("hold_rdata_l1", rdata[0], 32'hDEADBEEF);
         if (c >= 3) chk("hold_rdata_l3", rdata[1], 32'hDEADBEEF);
         if (c < 8) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("release_valid_l1", 32'(rvld[0]), 32'd0);
      chk("release_valid_l3", 32'(rvld[1]), 32'd0);
      chk("release_ready_l1", 32'(rdy[0]), 32'd1);
      chk("release_ready_l3", 32'(rdy[1]), 32'd1);
   endtask

   task automatic reset_mid_test();
      @(negedge clk);
      req_we = 1'b0; req_size = 3'b010; req_addr = 17'h200; req_wdata = '0;
      rv = 2'b10; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rv = 2'b00;
      chk("midrst_busy_l3", 32'(rdy[1]), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready_l3", 32'(rdy[1]), 32'd1);
      for (int c = 0; c < 4; c++) begin
         chk("midrst_novalid_l3", 32'(rvld[1]), 32'd0);
         @(negedge clk);
      end
   endtask

   // Latency-3 instance only: req_valid stays high, next request presented after each accept.
   task automatic b2b_test();
      logic [16:0] addrs [4];
      logic [2:0]  sizes [4];
      logic [31:0] exps  [4];
      int          k, r;
      logic        acc;
      addrs[0] = 17'h100;   sizes[0] = 3'b010; exps[0] = 32'hDEADBEEF;
      addrs[1] = 17'h200;   sizes[1] = 3'b010; exps[1] = 32'hA5C33344;
      addrs[2] = 17'h1FFFC; sizes[2] = 3'b010; exps[2] = 32'hCAFEF00D;
      addrs[3] = 17'h102;   sizes[3] = 3'b101; exps[3] = 32'h0000DEAD;
      k = 0; r = 0;
      @(negedge clk);
      req_we = 1'b0; req_size = sizes[0]; req_addr = addrs[0]; req_wdata = '0;
      rv = 2'b10; rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
         acc = rdy[1] & rv[1];
         if (rvld[1]) begin
            chk("b2b_rdata", rdata[1], exps[r]);
            chk("b2b_err", 32'(rerr[1]), 32'd0);
            r++;
         end
         @(negedge clk);
         if (acc) begin
            k++;
            if (k < 4) begin
               req_size = sizes[k]; req_addr = addrs[k];
            end else begin
               rv = 2'b00;
            end
         end
      end
      chk("b2b_count", 32'(r), 32'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rv = 2'b00; rsp_ready = 1'b1;
      req_we = 1'b0; req_size = 3'b000; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("reset_req_ready", 32'(rdy[i]), 32'd1);
         chk("reset_rsp_valid", 32'(rvld[i]), 32'd0);
         chk("reset_rsp_rdata", rdata[i], 32'd0);
         chk("reset_rsp_err", 32'(rerr[i]), 32'd0);
      end

      txn("sw100",  1'b1, 3'b010, 17'h100,   32'hDEADBEEF, 32'h0,        1'b0);
      txn("lw100",  1'b0, 3'b010, 17'h100,   32'h0,        32'hDEADBEEF, 1'b0);
      txn("sw200",  1'b1, 3'b010, 17'h200,   32'h11223344, 32'h0,        1'b0);
      txn("sb203",  1'b1, 3'b000, 17'h203,   32'h00000080, 32'h0,        1'b0);
      txn("lb203",  1'b0, 3'b000, 17'h203,   32'h0,        32'hFFFFFF80, 1'b0);
      txn("lbu203", 1'b0, 3'b100, 17'h203,   32'h0,        32'h00000080, 1'b0);
      txn("lw200",  1'b0, 3'b010, 17'h200,   32'h0,        32'h80223344, 1'b0);
      txn("lh101",  1'b0, 3'b001, 17'h101,   32'h0,        32'h0,        1'b1);
      txn("sw102",  1'b1, 3'b010, 17'h102,   32'h12345678, 32'h0,        1'b1);
      txn("lw100b", 1'b0, 3'b010, 17'h100,   32'h0,        32'hDEADBEEF, 1'b0);
      txn("sh202",  1'b1, 3'b001, 17'h202,   32'h0000A5C3, 32'h0,        1'b0);
      txn("lh202",  1'b0, 3'b001, 17'h202,   32'h0,        32'hFFFFA5C3, 1'b0);
      txn("lhu202", 1'b0, 3'b101, 17'h202,   32'h0,        32'h0000A5C3, 1'b0);
      txn("lb201",  1'b0, 3'b000, 17'h201,   32'h0,        32'h00000033, 1'b0);
      txn("ld_sz3", 1'b0, 3'b011, 17'h200,   32'h0,        32'h0,        1'b1);
      txn("st_bu",  1'b1, 3'b100, 17'h200,   32'h000000FF, 32'h0,        1'b1);
      txn("lw200b", 1'b0, 3'b010, 17'h200,   32'h0,        32'hA5C33344, 1'b0);
      txn("swtop",  1'b1, 3'b010, 17'h1FFFC, 32'hCAFEF00D, 32'h0,        1'b0);
      txn("lwtop",  1'b0, 3'b010, 17'h1FFFC, 32'h0,        32'hCAFEF00D, 1'b0);

      hold_test();
      reset_mid_test();
      b2b_test();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
